// File: rtl/converter_sequencer.sv
// Power-stage start-up sequencer: IDLE -> BOOT (bootstrap charge) -> RAMP -> RUN, with latched FAULT.
// Optional macro SEQ_ADC_OR_TRIP_EN adds the ADC over-range flag to the trip filter.
module converter_sequencer #(
  parameter int BOOT_CYCLES = 1000,
  parameter int RAMP_DIV    = 100000,
  parameter int PHI_START   = 0,
  parameter int PHI_MAX     = 180,
  parameter int FAULT_HOLD  = 100000
) (
  input  logic        i_clock,
  input  logic        i_RESET,
  input  logic        i_enable,
  input  logic        i_shoot_through,
  input  logic        i_adc_or,
  input  logic [31:0] i_phi_target,
  output logic [31:0] o_phi,
  output logic        o_bootstrap,
  output logic        o_on,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] BOOT_LAST   = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] DIV_LAST    = 32'(RAMP_DIV - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(FAULT_HOLD - 1);
  localparam logic [31:0] PHI_START_W = 32'(PHI_START);
  localparam logic [31:0] PHI_MAX_W   = 32'(PHI_MAX);

  // One-unit move toward the target; never passes it.
  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt);
    if (cur < tgt) begin
      step_toward = cur + 32'd1;
    end else if (cur > tgt) begin
      step_toward = cur - 32'd1;
    end else begin
      step_toward = cur;
    end
  endfunction

  state_t      state_r, state_next_s;
  logic [31:0] phi_r, phi_next_s;
  logic [31:0] boot_cnt_r, boot_cnt_next_s;
  logic [31:0] div_cnt_r, div_cnt_next_s;
  logic [31:0] fault_cnt_r, fault_cnt_next_s;
  logic        trip_prev_r, trip_prev_next_s;
  logic        on_r, boot_r, fault_r;
  logic        trip_in_s, trip_s;
  logic [31:0] eff_target_s;

`ifdef SEQ_ADC_OR_TRIP_EN
  assign trip_in_s = i_shoot_through | i_adc_or;
`else
  logic unused_adc_or_s;
  assign unused_adc_or_s = i_adc_or;
  assign trip_in_s       = i_shoot_through;
`endif

  // Two consecutive high samples make a trip; the previous sample is held in trip_prev_r.
  assign trip_s       = trip_in_s & trip_prev_r;
  assign eff_target_s = (i_phi_target > PHI_MAX_W) ? PHI_MAX_W : i_phi_target;

  // Next-state, counter and phi logic; defaults are the cleared values.
  always_comb begin
    state_next_s     = state_r;
    phi_next_s       = PHI_START_W;
    boot_cnt_next_s  = 32'd0;
    div_cnt_next_s   = 32'd0;
    fault_cnt_next_s = 32'd0;
    trip_prev_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          state_next_s = ST_BOOT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BOOT: begin
        trip_prev_next_s = trip_in_s;
        if (trip_s) begin
          state_next_s     = ST_FAULT;
          trip_prev_next_s = 1'b0;
        end else if (!i_enable) begin
          state_next_s     = ST_IDLE;
          trip_prev_next_s = 1'b0;
        end else if (boot_cnt_r == BOOT_LAST) begin
          state_next_s = ST_RAMP;
        end else begin
          state_next_s    = ST_BOOT;
          boot_cnt_next_s = boot_cnt_r + 32'd1;
        end
      end
      ST_RAMP, ST_RUN: begin
        trip_prev_next_s = trip_in_s;
        if (trip_s) begin
          state_next_s     = ST_FAULT;
          trip_prev_next_s = 1'b0;
        end else if (!i_enable) begin
          state_next_s     = ST_IDLE;
          trip_prev_next_s = 1'b0;
        end else begin
          if (div_cnt_r == DIV_LAST) begin
            phi_next_s     = step_toward(phi_r, eff_target_s);
            div_cnt_next_s = 32'd0;
          end else begin
            phi_next_s     = phi_r;
            div_cnt_next_s = div_cnt_r + 32'd1;
          end
          // RUN is entered together with the phi value that reaches the target.
          if ((state_r == ST_RAMP) && (phi_next_s == eff_target_s)) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = state_r;
          end
        end
      end
      ST_FAULT: begin
        if ((fault_cnt_r == HOLD_LAST) && !i_enable) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s     = ST_FAULT;
          fault_cnt_next_s = (fault_cnt_r == HOLD_LAST) ? fault_cnt_r : (fault_cnt_r + 32'd1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs, with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      state_r     <= ST_IDLE;
      phi_r       <= PHI_START_W;
      boot_cnt_r  <= 32'd0;
      div_cnt_r   <= 32'd0;
      fault_cnt_r <= 32'd0;
      trip_prev_r <= 1'b0;
      on_r        <= 1'b0;
      boot_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      phi_r       <= phi_next_s;
      boot_cnt_r  <= boot_cnt_next_s;
      div_cnt_r   <= div_cnt_next_s;
      fault_cnt_r <= fault_cnt_next_s;
      trip_prev_r <= trip_prev_next_s;
      on_r        <= (state_next_s == ST_RAMP) || (state_next_s == ST_RUN);
      boot_r      <= (state_next_s == ST_BOOT);
      fault_r     <= (state_next_s == ST_FAULT);
    end
  end

  assign o_phi       = phi_r;
  assign o_state     = state_r;
  assign o_on        = on_r;
  assign o_bootstrap = boot_r;
  assign o_fault     = fault_r;

endmodule

// File: tb/tb_converter_sequencer.sv
// Directed bench for converter_sequencer: per-cycle vector tables plus hand-written ramp sequences.
module tb_converter_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, en, st, adc;
  logic [31:0] tgt, phi;
  logic        boot, on, fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  converter_sequencer #(
    .BOOT_CYCLES(4), .RAMP_DIV(3), .PHI_START(0), .PHI_MAX(180), .FAULT_HOLD(5)
  ) dut (
    .i_clock(clk), .i_RESET(rst_n), .i_enable(en), .i_shoot_through(st), .i_adc_or(adc),
    .i_phi_target(tgt), .o_phi(phi), .o_bootstrap(boot), .o_on(on), .o_fault(fault), .o_state(state)
  );

  typedef struct {
    logic        rst_n, en, st, adc;
    logic [31:0] tgt;
    logic [2:0]  e_state;
    logic [31:0] e_phi;
    logic        e_on, e_boot, e_fault;
  } vec_t;

  vec_t tab_q[$];

`ifdef SEQ_ADC_OR_TRIP_EN
  localparam logic [2:0] ADC_TRIP_STATE = 3'd4;
`else
  localparam logic [2:0] ADC_TRIP_STATE = 3'd2;
`endif

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output flags follow directly from the state encoding.
  task automatic add(input logic r, input logic e, input logic s, input logic a,
                     input logic [31:0] t, input logic [2:0] es, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.en = e; v.st = s; v.adc = a; v.tgt = t;
    v.e_state = es; v.e_phi = ep;
    v.e_on    = (es == 3'd2) || (es == 3'd3);
    v.e_boot  = (es == 3'd1);
    v.e_fault = (es == 3'd4);
    tab_q.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tab_q.size(); i++) begin
      rst_n = tab_q[i].rst_n; en = tab_q[i].en; st = tab_q[i].st;
      adc = tab_q[i].adc; tgt = tab_q[i].tgt;
      tick;
      chk({tag, "_state"}, i, 32'(state), 32'(tab_q[i].e_state));
      chk({tag, "_phi"},   i, phi,        tab_q[i].e_phi);
      chk({tag, "_on"},    i, 32'(on),    32'(tab_q[i].e_on));
      chk({tag, "_boot"},  i, 32'(boot),  32'(tab_q[i].e_boot));
      chk({tag, "_fault"}, i, 32'(fault), 32'(tab_q[i].e_fault));
    end
    tab_q.delete();
  endtask

  // Run until phi reaches goal; every change must be one unit toward it, three clocks apart.
  task automatic slew_to(input string tag, input logic [31:0] goal, input int budget);
    logic [31:0] prev;
    int          last_chg;
    bit          reached;
    prev = phi; last_chg = -1; reached = 1'b0;
    for (int c = 0; c < budget && !reached; c++) begin
      tick;
      if (phi != prev) begin
        chk({tag, "_stepsize"}, c, phi, (goal > prev) ? prev + 32'd1 : prev - 32'd1);
        if (last_chg >= 0) chk({tag, "_gap"}, c, 32'(c - last_chg), 32'd3);
        last_chg = c;
        prev = phi;
      end
      if (phi == goal) reached = 1'b1;
    end
    chk({tag, "_reached"}, 0, 32'(reached), 32'd1);
    for (int c = 0; c < 7; c++) begin
      tick;
      chk({tag, "_hold_phi"}, c, phi, goal);
      chk({tag, "_hold_state"}, c, 32'(state), 32'd3);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; st = 1'b0; adc = 1'b0; tgt = 32'd0;

    // Reset, bootstrap for 4 clocks, ramp 0,1,2 at one unit per 3 clocks, RUN with phi=2.
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd2, 32'd0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd2, 32'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd3, 32'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd3, 32'd2);
    // Single-clock shoot-through glitch is filtered.
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd3, 32'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd3, 32'd2);
    run_table("start");

    // Clamped climb to PHI_MAX, then step down to 178.
    tgt = 32'd500;
    slew_to("climb", 32'd180, 700);
    tgt = 32'd178;
    slew_to("down", 32'd178, 30);

    // Two-clock shoot-through trips; FAULT holds while enable stays high.
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd178, 3'd3, 32'd178);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd178, 3'd4, 32'd0);
    for (int i = 0; i < 12; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd178, 3'd4, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd178, 3'd0, 32'd0);
    // Trip in BOOT; enable drops after 2 clocks, exit only after 5 clocks in FAULT.
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd0, 32'd0);
    // Trip and enable drop together: FAULT wins.
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 3'd4, 32'd0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd0, 32'd0);
    // ADC over-range in RAMP: trips only when the option is built in.
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd2, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 3'd2, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'd2, ADC_TRIP_STATE, 32'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 3'd0, 32'd0);
    // Enable drop in RAMP returns to IDLE.
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd2, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd0, 32'd0);
    // Reset in BOOT, then a full 4-clock bootstrap count on release.
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 3'd0, 32'd0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd2, 32'd0);
    // Reset overrides FAULT and active trip inputs.
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd2, 32'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd4, 32'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 3'd0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 3'd0, 32'd0);
    // Trip input ignored in IDLE and the filter does not carry into BOOT.
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 3'd0, 32'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 3'd1, 32'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 3'd1, 32'd0);
    run_table("seq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/converter_sequencer.md
CONVERTER_SEQUENCER -- requirements
Module: converter_sequencer

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 1000, bootstrap-charge duration in clocks (10 us at 100 MHz).
REQ-002 SHALL have parameter RAMP_DIV, default 100000, clocks per one-unit phi step.
REQ-003 SHALL have parameter PHI_START, default 0, phi value issued when entering RAMP.
REQ-004 SHALL have parameter PHI_MAX, default 180, upper clamp on phi.
REQ-005 SHALL have parameter FAULT_HOLD, default 100000, minimum clocks spent in FAULT.
REQ-006 SHALL have port i_clock, input, 1 bit: single clock (clk_100M); all logic on its rising edge.
REQ-007 SHALL have port i_RESET, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port i_enable, input, 1 bit: debounced converter enable request.
REQ-009 SHALL have port i_shoot_through, input, 1 bit: high when (Q1&Q3)|(Q2&Q4).
REQ-010 SHALL have port i_adc_or, input, 1 bit: ADA_OR|ADB_OR.
REQ-011 SHALL have port i_phi_target, input, 32 bit unsigned: requested phi.
REQ-012 SHALL have port o_phi, output, 32 bit unsigned: slew-limited phi fed to hybrid_control_theta_phi.
REQ-013 SHALL have port o_bootstrap, output, 1 bit: force low-side MOSFETs on, high side off.
REQ-014 SHALL have port o_on, output, 1 bit: hybrid-control MOSFET drive passes through.
REQ-015 SHALL have port o_fault, output, 1 bit: fault latched.
REQ-016 SHALL have port o_state, output, 3 bit: IDLE=0, BOOT=1, RAMP=2, RUN=3, FAULT=4.

Function
REQ-017 SHALL be an FSM with states IDLE, BOOT, RAMP, RUN, FAULT; all outputs registered.
REQ-018 IDLE: o_on=0, o_bootstrap=0, o_phi=PHI_START; i_enable=1 -> BOOT next cycle.
REQ-019 BOOT: o_bootstrap=1, o_on=0; after exactly BOOT_CYCLES clocks -> RAMP.
REQ-020 RAMP/RUN: o_on=1, o_bootstrap=0; o_phi=PHI_START on RAMP entry.
REQ-021 Effective target SHALL be min(i_phi_target, PHI_MAX), compared unsigned on 32 bits.
REQ-022 Every RAMP_DIV clocks in RAMP/RUN, o_phi SHALL move one unit toward the effective target; equal means no change; never overshoot.
REQ-023 RAMP -> RUN on the cycle o_phi equals the effective target; RUN keeps tracking at the same slew, no return to RAMP.
REQ-024 i_enable=0 in BOOT/RAMP/RUN -> IDLE next cycle, counters cleared.
REQ-025 A trip SHALL be i_shoot_through high (or i_adc_or high, per REQ-032) on 2 consecutive clocks in BOOT/RAMP/RUN; trip -> FAULT next cycle.
REQ-026 Trip and i_enable=0 in the same cycle -> FAULT has priority.
REQ-027 FAULT: o_fault=1, o_on=0, o_bootstrap=0, o_phi=PHI_START; exit to IDLE only after FAULT_HOLD clocks AND i_enable=0; o_fault clears on exit.
REQ-028 Trip inputs are ignored in IDLE and FAULT; the glitch filter is cleared there.
REQ-029 Counters SHALL saturate or reload, never wrap; the RAMP_DIV divider restarts on RAMP entry.

Reset
REQ-030 i_RESET=0 at a rising edge -> state IDLE, o_phi=PHI_START, o_on=0, o_bootstrap=0, o_fault=0, o_state=0, all counters and filters 0.
REQ-031 Reset mid-operation (any state, including FAULT) SHALL take effect on the next edge and override all other inputs.

Configuration
REQ-032 Macro SEQ_ADC_OR_TRIP_EN: when defined, i_adc_or participates in trip detection per REQ-025; when undefined, i_adc_or is unused and only i_shoot_through trips.

Verification (BOOT_CYCLES=4, RAMP_DIV=3, PHI_START=0, PHI_MAX=180, FAULT_HOLD=5)
REQ-033 Reset, then i_enable=1 with i_phi_target=2 -> o_bootstrap=1 for 4 clocks, then RAMP; o_phi goes 0,1,2 every 3 clocks; RUN (o_state=3) on the cycle o_phi=2.
REQ-034 In RUN with o_phi=2, i_phi_target=500 -> o_phi climbs at one unit per 3 clocks and stops at 180; then i_phi_target=178 -> o_phi steps down to 178.
REQ-035 In RUN, i_shoot_through high for 1 clock -> no fault; high for 2 clocks -> FAULT next cycle, o_on=0, o_phi=0, o_fault=1.
REQ-036 In FAULT with i_enable held at 1 -> stays in FAULT indefinitely; i_enable=0 after 2 clocks -> IDLE once 5 clocks have elapsed in FAULT.
REQ-037 i_adc_or high for 2 clocks in RAMP -> FAULT with SEQ_ADC_OR_TRIP_EN defined; no state change without it.
REQ-038 i_RESET=0 during BOOT with i_enable=1 -> IDLE and all outputs at reset values on the next edge; on release, BOOT restarts with a full 4-clock count.
